// File: rtl/serial_subtractor.sv
// Serial subtractor: diff = minuend - subtrahend - borrow_in, DIGIT bits per clock.
// Latency: start accepted at edge t, results and done visible after edge t+N (N = WIDTH/DIGIT).
// Backpressure: start is ignored while busy; a start seen in DONE is accepted back-to-back.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter combinations that cannot be sliced evenly.
  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;
  logic             brw;

  logic             accept;
  logic             last;
  logic [DIGIT-1:0] m_sl;
  logic [DIGIT-1:0] s_sl;
  logic [DIGIT-1:0] d_sl;
  logic [DIGIT:0]   sl_full;
  logic             sl_b;
  logic             msb_bin;

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign accept = start && (state != S_RUN);
  assign last   = (cnt == CW'(N - 1));

  // One digit of the borrow chain; the accumulator copy with the new digit merged in
  // is what gets published on the last slice, so the final digit is never lost.
  always_comb begin
    m_sl    = m_q[int'(cnt) * DIGIT +: DIGIT];
    s_sl    = s_q[int'(cnt) * DIGIT +: DIGIT];
    sl_full = {1'b0, m_sl} - {1'b0, s_sl} - {{DIGIT{1'b0}}, brw};
    d_sl    = sl_full[DIGIT-1:0];
    sl_b    = sl_full[DIGIT];
    // Bit-level difference is m ^ s ^ borrow_in, so the borrow entering the top bit
    // of this slice falls out of the operand and result top bits.
    msb_bin = m_sl[DIGIT-1] ^ s_sl[DIGIT-1] ^ d_sl[DIGIT-1];
    acc_nxt = acc_q;
    acc_nxt[int'(cnt) * DIGIT +: DIGIT] = d_sl;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE and DONE both accept a new request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, digit iteration and result publication on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      s_q        <= '0;
      acc_q      <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      m_q   <= minuend;
      s_q   <= subtrahend;
      brw   <= borrow_in;
      cnt   <= '0;
      acc_q <= '0;
    end else if (state == S_RUN) begin
      acc_q <= acc_nxt;
      brw   <= sl_b;
      cnt   <= cnt + 1'b1;
      if (last) begin
        cnt        <= '0;
        diff       <= acc_nxt;
        borrow_out <= sl_b;
        overflow   <= msb_bin ^ sl_b;
      end
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle, parametrised subtractor. It computes diff = minuend - subtrahend - borrow_in over WIDTH bits, processing DIGIT bits per clock with a registered borrow chain. It generalises the single-bit full subtractor into a start/busy/done handshaked datapath unit. It reports an unsigned borrow and a signed overflow, and sits beside the arithmetic atomics as the area-efficient wide subtractor.

Parameters:
WIDTH, 32, operand/result width in bits; WIDTH >= 1
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0 (elaboration error otherwise)
(derived) N = WIDTH/DIGIT, number of RUN cycles

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy==0
minuend  input  WIDTH  operand A; latched on accepted start
subtrahend  input  WIDTH  operand B; latched on accepted start
borrow_in  input  1  initial borrow; latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; results valid from this cycle
diff  output  WIDTH  result, registered
borrow_out  output  1  borrow out of MSB (unsigned underflow)
overflow  output  1  signed overflow: borrow into MSB XOR borrow out of MSB

Behaviour:
- Reset (async assert, sync-to-clk release irrelevant to spec): state=IDLE. busy=0, done=0, diff=0, borrow_out=0, overflow=0. Internal counter, borrow and operand registers are cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1, latch minuend, subtrahend and borrow_in. Clear cnt to 0, set the internal borrow to borrow_in, then go to RUN. Otherwise stay in IDLE.
- RUN: busy=1. Each cycle, take slice k=cnt (bits k*DIGIT+DIGIT-1 : k*DIGIT).
  - Compute {b, d} = m_slice - s_slice - borrow in DIGIT+1-bit arithmetic.
  - Store d into result slice k. The next borrow is b. cnt increments.
  - When cnt==N-1, this is the last slice: capture the MSB-level borrow-in for overflow, then go to DONE.
- DONE: done=1, busy=0. In this cycle diff, borrow_out and overflow are already updated from the completed operation.
  - If start=1, a new operation is accepted, same as in IDLE, and the FSM goes to RUN. Otherwise it goes to IDLE.
- Latency: start accepted at edge t; done is high in the cycle after edge t+N (N RUN cycles); throughput is one op per N+1 cycles. With DIGIT==WIDTH, N=1 and done is high 2 edges after start.
- diff, borrow_out and overflow change only on the edge entering DONE. They hold until the next completion; partial results are never visible.
- start while busy=1 is ignored: no restart and no queuing.
- Operand/borrow_in changes after acceptance have no effect.
- Arithmetic: borrow_out=1 iff minuend < subtrahend + borrow_in (unsigned). overflow=1 iff the two's-complement true result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Reset asserted mid-RUN or in DONE: immediate return to reset values and abandonment of the operation. After release, the next start behaves normally.
- done is never high for two consecutive cycles unless a back-to-back start was accepted in the DONE cycle. In that case the cycles are separated by N RUN cycles.

Test Plan:
1. WIDTH=1, DIGIT=1: apply all 8 (minuend, subtrahend, borrow_in) vectors → (diff, borrow_out) = 000→0,0; 001→1,1; 010→1,1; 011→0,1; 100→1,0; 101→0,0; 110→0,0; 111→1,1. Each done occurs exactly 2 edges after start.
2. WIDTH=32, DIGIT=4: 0x00000000 - 0x00000001, borrow_in=0 → diff=0xFFFFFFFF, borrow_out=1, overflow=0. busy is high for 8 cycles, and done is high 9 edges after start.
3. WIDTH=32, DIGIT=4: 0x80000000 - 0x00000000, borrow_in=1 → diff=0x7FFFFFFF, borrow_out=0, overflow=1. Also check 0x7FFFFFFF - 0xFFFFFFFF, borrow_in=0 → diff=0x80000000, borrow_out=1, overflow=1.
4. Handshake sequence:
   - Pulse start with 0x10 - 0x01, then pulse start again mid-RUN with different operands and change the operand inputs. Required: the single result diff=0x0000000F.
   - Then hold start high through DONE. Required: a second op is accepted and the next done arrives N+1 cycles later.
5. Drop rst_n low for 1 cycle during RUN cycle 3. Required: busy, done, diff, borrow_out and overflow all become 0 immediately, there is no done pulse, and a fresh 5 - 3 afterwards gives diff=2, borrow_out=0.
6. Random regression, 10k ops each at (WIDTH, DIGIT) = (32,1), (32,4), (32,32), (12,3). Required: results match a behavioural model of m - s - bin, including borrow_out and overflow, with latency N+1 asserted on every op.
